nibble_add_arb: RTL and testbench

NIBBLE_ADD_ARB -- requirements
Module: nibble_add_arb

---
 rtl/add_pkg.sv | 19 +
 rtl/nibble_add_arb_if.sv | 46 ++++
 rtl/nibble_adder.sv | 22 ++
 rtl/nibble_add_arb.sv | 140 ++++++++++++++
 tb/tb_nibble_add_arb.sv | 259 +++++++++++++++++++++++++
 5 files changed

// File: rtl/add_pkg.sv
// Shared definitions for the serial nibble adder with two-requester arbitration.
package add_pkg;

    // Width of one digit handled by the shared adder per cycle
    localparam int NIBBLE_W = 4;

    // Operation sequencing: wait for a request, add nibble by nibble, hold result
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Width of the nibble index register; never narrower than one bit
    function automatic int idx_width(input int nibbles);
        return (nibbles > 1) ? $clog2(nibbles) : 1;
    endfunction

endpackage

// File: rtl/nibble_add_arb_if.sv
// Request/response bundle between two requesters, the serial adder and its consumer.
interface nibble_add_arb_if
    import add_pkg::*;
#(
    parameter int NIBBLES = 4
) ();

    localparam int W = NIBBLE_W * NIBBLES;

    logic         req0_valid;
    logic         req0_ready;
    logic [W-1:0] req0_a;
    logic [W-1:0] req0_b;
    logic         req0_cin;

    logic         req1_valid;
    logic         req1_ready;
    logic [W-1:0] req1_a;
    logic [W-1:0] req1_b;
    logic         req1_cin;

    logic         rsp_valid;
    logic         rsp_ready;
    logic [W-1:0] rsp_sum;
    logic         rsp_carry;
    logic         rsp_id;

    // Adder side: accepts operands, produces the response
    modport slave (
        input  req0_valid, req0_a, req0_b, req0_cin,
        input  req1_valid, req1_a, req1_b, req1_cin,
        input  rsp_ready,
        output req0_ready, req1_ready,
        output rsp_valid, rsp_sum, rsp_carry, rsp_id
    );

    // Requester/consumer side
    modport master (
        output req0_valid, req0_a, req0_b, req0_cin,
        output req1_valid, req1_a, req1_b, req1_cin,
        output rsp_ready,
        input  req0_ready, req1_ready,
        input  rsp_valid, rsp_sum, rsp_carry, rsp_id
    );

endinterface

// File: rtl/nibble_adder.sv
// Combinational 4-bit adder with carry in and carry out; the single shared datapath adder.
module nibble_adder
    import add_pkg::*;
(
    input  logic [NIBBLE_W-1:0] a,
    input  logic [NIBBLE_W-1:0] b,
    input  logic                cin,
    output logic [NIBBLE_W-1:0] sum,
    output logic                cout
);

    logic [NIBBLE_W:0] total_s;

    // Full-width sum so the top bit is the carry out
    always_comb begin
        total_s = {1'b0, a} + {1'b0, b} + {{NIBBLE_W{1'b0}}, cin};
    end

    assign sum  = total_s[NIBBLE_W-1:0];
    assign cout = total_s[NIBBLE_W];

endmodule

// File: rtl/nibble_add_arb.sv
// Two requesters share one 4-bit adder; operands are summed LSB nibble first over
// NIBBLES cycles and the result is held until the consumer takes it.
module nibble_add_arb
    import add_pkg::*;
#(
    parameter int NIBBLES = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    nibble_add_arb_if.slave  bus
);

    localparam int W  = NIBBLE_W * NIBBLES;
    localparam int IW = idx_width(NIBBLES);
    localparam int SW = IW + 2;

    state_t          state_r;
    logic [IW-1:0]   idx_r;
    logic            carry_r;
    logic [W-1:0]    a_r;
    logic [W-1:0]    b_r;
    logic [W-1:0]    sum_r;
    logic            id_r;
    logic            ptr_r;        // index of the requester served last
    logic            rsp_valid_r;

    logic            grant_s;
    logic            ready0_s;
    logic            ready1_s;
    logic            hs_s;
    logic [SW-1:0]   shift_s;
    logic [NIBBLE_W-1:0] nib_a_s;
    logic [NIBBLE_W-1:0] nib_b_s;
    logic [NIBBLE_W-1:0] nib_sum_s;
    logic            nib_cout_s;
    logic [W-1:0]    nib_mask_s;
    logic [W-1:0]    nib_ins_s;

    // Round-robin grant; ready is offered only in IDLE and only outside reset
    always_comb begin
        grant_s  = 1'b0;
        ready0_s = 1'b0;
        ready1_s = 1'b0;
        if (bus.req0_valid && bus.req1_valid) begin
            grant_s = ~ptr_r;
        end else if (bus.req1_valid) begin
            grant_s = 1'b1;
        end else begin
            grant_s = 1'b0;
        end
        if (rst_n && (state_r == IDLE)) begin
            ready0_s = bus.req0_valid & ~grant_s;
            ready1_s = bus.req1_valid & grant_s;
        end else begin
            ready0_s = 1'b0;
            ready1_s = 1'b0;
        end
    end

    assign hs_s = ready0_s | ready1_s;

    // Select the current nibble of each operand and build the write mask for the sum
    always_comb begin
        shift_s    = {idx_r, 2'b00};
        nib_a_s    = NIBBLE_W'(a_r >> shift_s);
        nib_b_s    = NIBBLE_W'(b_r >> shift_s);
        nib_mask_s = W'({NIBBLE_W{1'b1}}) << shift_s;
        nib_ins_s  = W'(nib_sum_s) << shift_s;
    end

    nibble_adder u_adder (
        .a    (nib_a_s),
        .b    (nib_b_s),
        .cin  (carry_r),
        .sum  (nib_sum_s),
        .cout (nib_cout_s)
    );

    // Operation sequencer with operand, sum, carry and response registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= IDLE;
            idx_r       <= {IW{1'b0}};
            carry_r     <= 1'b0;
            a_r         <= {W{1'b0}};
            b_r         <= {W{1'b0}};
            sum_r       <= {W{1'b0}};
            id_r        <= 1'b0;
            ptr_r       <= 1'b1;
            rsp_valid_r <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (hs_s) begin
                        a_r     <= grant_s ? bus.req1_a   : bus.req0_a;
                        b_r     <= grant_s ? bus.req1_b   : bus.req0_b;
                        carry_r <= grant_s ? bus.req1_cin : bus.req0_cin;
                        id_r    <= grant_s;
                        idx_r   <= {IW{1'b0}};
                        sum_r   <= {W{1'b0}};
                        state_r <= RUN;
                    end else begin
                        state_r <= IDLE;
                    end
                end
                RUN: begin
                    sum_r   <= (sum_r & ~nib_mask_s) | nib_ins_s;
                    carry_r <= nib_cout_s;
                    if (idx_r == IW'(NIBBLES - 1)) begin
                        state_r     <= DONE;
                        rsp_valid_r <= 1'b1;
                    end else begin
                        idx_r <= idx_r + IW'(1);
                    end
                end
                DONE: begin
                    if (bus.rsp_ready) begin
                        state_r     <= IDLE;
                        rsp_valid_r <= 1'b0;
                        ptr_r       <= id_r;
                    end else begin
                        state_r <= DONE;
                    end
                end
                default: begin
                    state_r     <= IDLE;
                    rsp_valid_r <= 1'b0;
                end
            endcase
        end
    end

    assign bus.req0_ready = ready0_s;
    assign bus.req1_ready = ready1_s;
    assign bus.rsp_valid  = rsp_valid_r;
    assign bus.rsp_sum    = sum_r;
    assign bus.rsp_carry  = carry_r;
    assign bus.rsp_id     = id_r;

endmodule

// File: tb/tb_nibble_add_arb.sv
// Self-checking bench: reference model of arbitration, latency and sum, plus directed cases.
module tb_nibble_add_arb;

    localparam int LAT4 = 5;   // handshake-to-first-valid for 4 nibbles

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   cyc = 0;
    int   n_vec = 0;
    int   n_err = 0;

    always #5 clk = ~clk;

    // Cycle counter, stable when sampled on the falling edge
    always @(posedge clk) cyc <= cyc + 1;

    nibble_add_arb_if #(.NIBBLES(4)) bus4 ();
    nibble_add_arb_if #(.NIBBLES(1)) bus1 ();

    nibble_add_arb #(.NIBBLES(4)) dut4 (.clk(clk), .rst_n(rst_n), .bus(bus4));
    nibble_add_arb #(.NIBBLES(1)) dut1 (.clk(clk), .rst_n(rst_n), .bus(bus1));

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Reference model state for the 4-nibble instance
    bit          m_pend = 1'b0;
    int          m_hs = 0;
    logic [15:0] m_sum = 16'h0000;
    logic        m_carry = 1'b0;
    logic        m_id = 1'b0;
    bit          m_favour = 1'b0;  // requester preferred when both ask

    // Compare every cycle against the model of grant, latency and arithmetic
    always @(negedge clk) begin : monitor
        logic e0, e1, erv;
        logic [16:0] tot;
        if (!rst_n) begin
            check_val("rst_ready0", 64'(bus4.req0_ready), 64'd0);
            check_val("rst_ready1", 64'(bus4.req1_ready), 64'd0);
            check_val("rst_valid",  64'(bus4.rsp_valid),  64'd0);
            check_val("rst_sum",    64'(bus4.rsp_sum),    64'd0);
            check_val("rst_carry",  64'(bus4.rsp_carry),  64'd0);
            check_val("rst_id",     64'(bus4.rsp_id),     64'd0);
            m_pend   = 1'b0;
            m_favour = 1'b0;
        end else begin
            e0  = !m_pend && bus4.req0_valid && (!bus4.req1_valid || !m_favour);
            e1  = !m_pend && bus4.req1_valid && (!bus4.req0_valid ||  m_favour);
            erv = m_pend && ((cyc - m_hs) >= LAT4);
            check_val("ready0", 64'(bus4.req0_ready), 64'(e0));
            check_val("ready1", 64'(bus4.req1_ready), 64'(e1));
            check_val("rsp_valid", 64'(bus4.rsp_valid), 64'(erv));
            if (erv) begin
                check_val("rsp_sum",   64'(bus4.rsp_sum),   64'(m_sum));
                check_val("rsp_carry", 64'(bus4.rsp_carry), 64'(m_carry));
                check_val("rsp_id",    64'(bus4.rsp_id),    64'(m_id));
            end
            if (e0 || e1) begin
                if (e1) tot = {1'b0, bus4.req1_a} + {1'b0, bus4.req1_b} + 17'(bus4.req1_cin);
                else    tot = {1'b0, bus4.req0_a} + {1'b0, bus4.req0_b} + 17'(bus4.req0_cin);
                m_sum   = tot[15:0];
                m_carry = tot[16];
                m_id    = e1;
                m_pend  = 1'b1;
                m_hs    = cyc;
            end else if (erv && bus4.rsp_ready) begin
                m_pend   = 1'b0;
                m_favour = !m_id;
            end
        end
    end

    // One request on the 4-nibble instance; called just after a rising edge
    task automatic send4(input bit id, input logic [15:0] a, input logic [15:0] b, input logic cin,
                         output logic [15:0] s, output logic c, output logic i, output int lat);
        int hs;
        bit got;
        if (id) begin
            bus4.req1_valid = 1'b1; bus4.req1_a = a; bus4.req1_b = b; bus4.req1_cin = cin;
        end else begin
            bus4.req0_valid = 1'b1; bus4.req0_a = a; bus4.req0_b = b; bus4.req0_cin = cin;
        end
        got = 1'b0;
        for (int k = 0; k < 20 && !got; k++) begin
            @(negedge clk);
            if (id ? bus4.req1_ready : bus4.req0_ready) got = 1'b1;
        end
        check_val("hs_seen", 64'(got), 64'd1);
        hs = cyc;
        @(posedge clk); #1;
        bus4.req0_valid = 1'b0;
        bus4.req1_valid = 1'b0;
        got = 1'b0;
        for (int k = 0; k < 20 && !got; k++) begin
            @(negedge clk);
            if (bus4.rsp_valid) got = 1'b1;
        end
        lat = got ? (cyc - hs) : -1;
        s = bus4.rsp_sum;
        c = bus4.rsp_carry;
        i = bus4.rsp_id;
        @(posedge clk); #1;
    endtask

    initial begin : watchdog
        #400000;
        $display("FAIL watchdog timeout");
        $fatal(1, "bench timed out");
    end

    initial begin : stim
        logic [15:0] s;
        logic c, i;
        int lat, cnt;
        bit got;
        logic ids [4];

        bus4.req0_valid = 1'b0; bus4.req1_valid = 1'b0; bus4.rsp_ready = 1'b1;
        bus4.req0_a = '0; bus4.req0_b = '0; bus4.req0_cin = 1'b0;
        bus4.req1_a = '0; bus4.req1_b = '0; bus4.req1_cin = 1'b0;
        bus1.req0_valid = 1'b0; bus1.req1_valid = 1'b0; bus1.rsp_ready = 1'b1;
        bus1.req0_a = '0; bus1.req0_b = '0; bus1.req0_cin = 1'b0;
        bus1.req1_a = '0; bus1.req1_b = '0; bus1.req1_cin = 1'b0;
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        check_val("rst1_valid", 64'(bus1.rsp_valid), 64'd0);
        check_val("rst1_sum",   64'(bus1.rsp_sum),   64'd0);
        #1 rst_n = 1'b1;

        // Simple carry between nibbles, req0
        send4(1'b0, 16'h0001, 16'h000F, 1'b0, s, c, i, lat);
        check_val("d1_sum", 64'(s), 64'h0010);
        check_val("d1_carry", 64'(c), 64'd0);
        check_val("d1_id", 64'(i), 64'd0);
        check_val("d1_lat", 64'(lat), 64'd5);

        // Carry ripples through every nibble, req1
        send4(1'b1, 16'hFFFF, 16'h0000, 1'b1, s, c, i, lat);
        check_val("d2_sum", 64'(s), 64'h0000);
        check_val("d2_carry", 64'(c), 64'd1);
        check_val("d2_id", 64'(i), 64'd1);
        check_val("d2_lat", 64'(lat), 64'd5);

        // Consumer stalls three cycles in DONE
        bus4.rsp_ready = 1'b0;
        send4(1'b0, 16'h9F0F, 16'h7101, 1'b1, s, c, i, lat);
        check_val("stall_sum0", 64'(s), 64'h1011);
        check_val("stall_carry0", 64'(c), 64'd1);
        bus4.req1_valid = 1'b1;
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            check_val("stall_valid", 64'(bus4.rsp_valid), 64'd1);
            check_val("stall_sum", 64'(bus4.rsp_sum), 64'h1011);
            check_val("stall_carry", 64'(bus4.rsp_carry), 64'd1);
            check_val("stall_id", 64'(bus4.rsp_id), 64'd0);
            check_val("stall_rdy0", 64'(bus4.req0_ready), 64'd0);
            check_val("stall_rdy1", 64'(bus4.req1_ready), 64'd0);
            @(posedge clk); #1;
        end
        bus4.req1_valid = 1'b0;
        bus4.rsp_ready = 1'b1;
        @(negedge clk);
        check_val("stall_4th_valid", 64'(bus4.rsp_valid), 64'd1);
        @(negedge clk);
        check_val("stall_done", 64'(bus4.rsp_valid), 64'd0);
        @(posedge clk); #1;

        // Reset pulse in the second RUN cycle
        bus4.req0_valid = 1'b1; bus4.req0_a = 16'h0F0F; bus4.req0_b = 16'hF0F0; bus4.req0_cin = 1'b1;
        got = 1'b0;
        for (int k = 0; k < 20 && !got; k++) begin
            @(negedge clk);
            if (bus4.req0_ready) got = 1'b1;
        end
        check_val("rr_hs", 64'(got), 64'd1);
        @(posedge clk); #1 bus4.req0_valid = 1'b0;
        @(posedge clk); #2 rst_n = 1'b0;
        #1;
        check_val("arst_valid", 64'(bus4.rsp_valid), 64'd0);
        check_val("arst_sum", 64'(bus4.rsp_sum), 64'd0);
        check_val("arst_carry", 64'(bus4.rsp_carry), 64'd0);
        check_val("arst_id", 64'(bus4.rsp_id), 64'd0);
        @(posedge clk); #1 rst_n = 1'b1;
        send4(1'b0, 16'h1234, 16'h4321, 1'b0, s, c, i, lat);
        check_val("post_rst_sum", 64'(s), 64'h5555);
        check_val("post_rst_carry", 64'(c), 64'd0);
        check_val("post_rst_lat", 64'(lat), 64'd5);

        // Both requesters held from reset: grants alternate starting with req0
        rst_n = 1'b0;
        bus4.req0_valid = 1'b1; bus4.req0_a = 16'($urandom); bus4.req0_b = 16'($urandom);
        bus4.req1_valid = 1'b1; bus4.req1_a = 16'($urandom); bus4.req1_b = 16'($urandom);
        @(posedge clk); #1 rst_n = 1'b1;
        cnt = 0;
        for (int k = 0; k < 80 && cnt < 4; k++) begin
            @(negedge clk);
            if (bus4.rsp_valid && bus4.rsp_ready) begin
                ids[cnt] = bus4.rsp_id;
                cnt++;
            end
        end
        check_val("rr_count", 64'(cnt), 64'd4);
        check_val("rr_id0", 64'(ids[0]), 64'd0);
        check_val("rr_id1", 64'(ids[1]), 64'd1);
        check_val("rr_id2", 64'(ids[2]), 64'd0);
        check_val("rr_id3", 64'(ids[3]), 64'd1);
        @(posedge clk); #1;
        bus4.req0_valid = 1'b0;
        bus4.req1_valid = 1'b0;

        // Randomized traffic, checked cycle by cycle by the monitor
        for (int k = 0; k < 400; k++) begin
            @(posedge clk); #1;
            bus4.req0_valid = 1'($urandom);
            bus4.req1_valid = 1'($urandom);
            bus4.req0_a = 16'($urandom); bus4.req0_b = 16'($urandom); bus4.req0_cin = 1'($urandom);
            bus4.req1_a = 16'($urandom); bus4.req1_b = 16'($urandom); bus4.req1_cin = 1'($urandom);
            bus4.rsp_ready = ($urandom_range(0, 3) != 0);
        end
        @(posedge clk); #1;
        bus4.req0_valid = 1'b0;
        bus4.req1_valid = 1'b0;
        bus4.rsp_ready = 1'b1;
        repeat (12) @(posedge clk);
        #1;

        // Single-nibble instance
        bus1.req0_valid = 1'b1; bus1.req0_a = 4'hB; bus1.req0_b = 4'hF; bus1.req0_cin = 1'b1;
        got = 1'b0;
        for (int k = 0; k < 20 && !got; k++) begin
            @(negedge clk);
            if (bus1.req0_ready) got = 1'b1;
        end
        check_val("n1_hs", 64'(got), 64'd1);
        lat = cyc;
        @(posedge clk); #1 bus1.req0_valid = 1'b0;
        got = 1'b0;
        for (int k = 0; k < 20 && !got; k++) begin
            @(negedge clk);
            if (bus1.rsp_valid) got = 1'b1;
        end
        lat = got ? (cyc - lat) : -1;
        check_val("n1_lat", 64'(lat), 64'd2);
        check_val("n1_sum", 64'(bus1.rsp_sum), 64'hB);
        check_val("n1_carry", 64'(bus1.rsp_carry), 64'd1);
        check_val("n1_id", 64'(bus1.rsp_id), 64'd0);
        @(posedge clk); #1;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
